// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues imem reads and presents instr/opcode/pc to decode.
// Latency: read issued the cycle after a pc update, word registered at the output one cycle later.
// Backpressure: stall holds the output; a 1-entry skid absorbs the in-flight word, and issue stops at occupancy 2.
module instr_fetch #(
    parameter int PC_W     = 16,
    parameter int INSTR_W  = 32,
    parameter int OPC_MSB  = 31,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_wr_busy,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [11:0]        opcode,
    output logic [PC_W-1:0]    instr_pc
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t             state, state_nxt;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    rd_pc;
    logic               inflight;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    logic               pop;
    logic               issue;
    logic [1:0]         occ;

    always_comb begin
        state_nxt = state;
        pop       = instr_valid & ~stall;
        occ       = {1'b0, instr_valid} + {1'b0, skid_valid} + {1'b0, inflight};
        issue     = 1'b0;
        if (state == BOOT) begin
            state_nxt = RUN;
        end else begin
            // occ - pop <= 1, rearranged to avoid unsigned underflow
            issue = ~redirect & ~imem_wr_busy & (occ <= (2'd1 + {1'b0, pop}));
        end
    end

    assign imem_rd_en = issue;
    assign imem_addr  = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= PC_W'(RESET_PC);
            rd_pc       <= '0;
            inflight    <= 1'b0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            opcode      <= '0;
            instr_pc    <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (issue) begin
                pc    <= pc + {{(PC_W-1){1'b0}}, 1'b1};
                rd_pc <= pc;
            end
            if (redirect) begin
                // issue is already suppressed, so inflight clears and the stale word is ignored
                pc          <= redirect_pc;
                instr_valid <= 1'b0;
                skid_valid  <= 1'b0;
            end else if (pop && skid_valid) begin
                instr       <= skid_instr;
                opcode      <= skid_instr[OPC_MSB -: 12];
                instr_pc    <= skid_pc;
                instr_valid <= 1'b1;
                if (inflight) begin
                    skid_instr <= imem_rdata;
                    skid_pc    <= rd_pc;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (inflight) begin
                if (!skid_valid && (!instr_valid || pop)) begin
                    instr       <= imem_rdata;
                    opcode      <= imem_rdata[OPC_MSB -: 12];
                    instr_pc    <= rd_pc;
                    instr_valid <= 1'b1;
                end else begin
                    skid_instr <= imem_rdata;
                    skid_pc    <= rd_pc;
                    skid_valid <= 1'b1;
                end
            end else if (pop) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected pc streams are queued by stimulus, a monitor checks each consumed word.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit pc instance
    logic        rst_n, imem_rd_en, imem_wr_busy, redirect, stall, instr_valid;
    logic [15:0] imem_addr, redirect_pc, instr_pc;
    logic [31:0] imem_rdata, instr;
    logic [11:0] opcode;

    // 4-bit pc instance for wrap-around
    logic        rst4_n, imem_rd_en4, redirect4, instr_valid4;
    logic [3:0]  imem_addr4, redirect_pc4, instr_pc4;
    logic [31:0] imem_rdata4, instr4;
    logic [11:0] opcode4;

    instr_fetch #(.PC_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_wr_busy(imem_wr_busy), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .instr_valid(instr_valid),
        .instr(instr), .opcode(opcode), .instr_pc(instr_pc)
    );

    instr_fetch #(.PC_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .imem_rd_en(imem_rd_en4), .imem_addr(imem_addr4),
        .imem_rdata(imem_rdata4), .imem_wr_busy(1'b0), .redirect(redirect4),
        .redirect_pc(redirect_pc4), .stall(1'b0), .instr_valid(instr_valid4),
        .instr(instr4), .opcode(opcode4), .instr_pc(instr_pc4)
    );

    // imem[a] = {a[11:0], 20'h0}, one-cycle read
    always @(posedge clk) begin
        if (imem_rd_en)  imem_rdata  <= {imem_addr[11:0], 20'h0};
        if (imem_rd_en4) imem_rdata4 <= {8'h0, imem_addr4, 20'h0};
    end

    int checks = 0;
    int passes = 0;
    int pops_seen = 0;
    logic [15:0] exp_q[$];
    logic [3:0]  exp4_q[$];
    logic [15:0] e;
    logic [3:0]  e4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        else passes++;
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: output presented with no expected entry queued", name);
    endtask

    task automatic restart_stream(input logic [15:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 16'(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every consumed output must match the head of the expected stream
    always @(negedge clk) begin
        if (rst_n && instr_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                fail_now("sb_underflow");
            end else begin
                e = exp_q.pop_front();
                pops_seen++;
                check("sb_pc", 32'(instr_pc), 32'(e));
                check("sb_instr", instr, {e[11:0], 20'h0});
                check("sb_opcode", 32'(opcode), 32'(e[11:0]));
            end
        end
        if (rst4_n && instr_valid4 && !redirect4 && exp4_q.size() > 0) begin
            e4 = exp4_q.pop_front();
            check("wrap_pc", 32'(instr_pc4), 32'(e4));
            check("wrap_opcode", 32'(opcode4), {24'h0, 4'h0, e4});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_wr_busy = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        rst4_n = 1'b0; redirect4 = 1'b0; redirect_pc4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", instr, 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_pc", 32'(instr_pc), 0);
        check("rst_rd_en", 32'(imem_rd_en), 0);

        // 1: boot latency and streaming
        restart_stream(16'h0000);
        rst_n = 1'b1;
        tick();
        check("boot_rd_en", 32'(imem_rd_en), 1);
        check("boot_addr", 32'(imem_addr), 0);
        check("boot_valid_c1", 32'(instr_valid), 0);
        tick();
        check("boot_valid_c2", 32'(instr_valid), 0);
        check("boot_addr1", 32'(imem_addr), 1);
        tick();
        check("first_valid", 32'(instr_valid), 1);
        check("first_pc", 32'(instr_pc), 0);
        repeat (5) tick();

        // 2: three stall cycles with a read in flight
        stall = 1'b1;
        #1 check("stall_rd_c0", 32'(imem_rd_en), 0);
        tick();
        check("stall_rd_c1", 32'(imem_rd_en), 0);
        tick();
        check("stall_rd_c2", 32'(imem_rd_en), 0);
        tick();
        stall = 1'b0;
        #1 check("stall_release_rd", 32'(imem_rd_en), 1);
        repeat (6) tick();

        // 3: redirect while stalled with a read in flight
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0; stall = 1'b0;
        restart_stream(16'h0040);
        #1;
        check("redir_valid_t1", 32'(instr_valid), 0);
        check("redir_rd_en", 32'(imem_rd_en), 1);
        check("redir_addr", 32'(imem_addr), 32'h40);
        tick();
        check("redir_drop", 32'(instr_valid), 0);
        tick();
        check("redir_valid_t2", 32'(instr_valid), 1);
        check("redir_pc_t2", 32'(instr_pc), 32'h40);
        repeat (4) tick();

        // 4: imem write busy for three cycles
        imem_wr_busy = 1'b1;
        #1 check("busy_rd_c0", 32'(imem_rd_en), 0);
        tick();
        check("busy_rd_c1", 32'(imem_rd_en), 0);
        check("busy_last_word", 32'(instr_valid), 1);
        tick();
        check("busy_rd_c2", 32'(imem_rd_en), 0);
        check("busy_drained", 32'(instr_valid), 0);
        tick();
        imem_wr_busy = 1'b0;
        #1;
        check("busy_resume_rd", 32'(imem_rd_en), 1);
        check("busy_resume_addr", 32'(imem_addr), 32'(exp_q[0]));
        repeat (6) tick();

        // 6: asynchronous reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(instr_valid), 0);
        check("arst_rd_en", 32'(imem_rd_en), 0);
        restart_stream(16'h0000);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rerst_addr", 32'(imem_addr), 0);
        tick();
        tick();
        check("rerst_valid", 32'(instr_valid), 1);
        check("rerst_pc", 32'(instr_pc), 0);
        repeat (4) tick();

        // 5: 4-bit pc wraps after redirect to 0xE
        rst4_n = 1'b1;
        repeat (4) tick();
        redirect_pc4 = 4'hE; redirect4 = 1'b1;
        tick();
        redirect4 = 1'b0;
        exp4_q.delete();
        exp4_q.push_back(4'hE); exp4_q.push_back(4'hF);
        exp4_q.push_back(4'h0); exp4_q.push_back(4'h1);
        repeat (8) tick();
        check("wrap_drain", 32'(exp4_q.size()), 0);
        check("sb_activity", 32'(pops_seen >= 20), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
